f1_reaction_timer: RTL and testbench
====================================

// Module: f1_reaction_timer
// PURPOSE
//  Receiving end of the F1 start-light bar: consumes the 8-bit thermometer light pattern and decodes/validates it.
//  Once all 8 lights are lit, holds the sequencer, waits a pseudo-random delay, then signals lights-out.
//  Measures driver reaction (trigger edge) in ticks and returns the result over a valid/ready handshake.
//  Sits between the light-sequence FSM (whose en it gates via hold_seq) and the display/score logic.
// PARAMETERS
//  TICK_DIV   1000   clk cycles per time tick (prescaler); bench uses 4
//  MIN_HOLD   16     minimum lights-on hold, in ticks
//  HOLD_MASK  8'h3F  mask on LFSR value added to MIN_HOLD
//  SEED       8'hB8  LFSR reset value, must be non-zero
//  RES_W      16     width of reaction result, in ticks
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  lights_in  in   8      thermometer light pattern from sequencer (8'b0..8'b1111_1111)
//  trigger    in   1      driver button, already synchronised, level
//  hold_seq   out  1      1 = sequencer en must be forced low
//  lights_off out  1      1 while lights are commanded out (TIMING state)
//  lit_count  out  4      decoded number of lit lights, 0..8
//  code_err   out  1      1-cycle pulse: malformed or non-monotonic pattern
//  res_valid  out  1      result available
//  res_ready  in   1      consumer accepts result
//  res_time   out  RES_W  reaction time in ticks (0 when false_start)
//  res_false  out  1      result is a false start
// BEHAVIOUR
//  Reset: state IDLE; hold_seq=0, lights_off=0, code_err=0, res_valid=0, res_time=0, res_false=0, lit_count=0; LFSR=SEED; prescaler and counters=0.
//  Decode (combinational): lit_count = number of ones if lights_in is a valid thermometer code (ones contiguous from bit 0); invalid codes give lit_count=0 and are flagged as bad.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle outside reset.
//  Trigger edge: trig_rise = trigger & ~trigger_q (trigger_q is a 1-cycle register).
//  Prescaler: counts 0..TICK_DIV-1 only in HOLD/TIMING, cleared on state entry; tick pulses at wrap.
//  FSM:
//   IDLE: lit_count==1 -> ARMING; bad code -> code_err, stay in IDLE.
//   ARMING: each cycle lit_count must equal the previous value or previous+1.
//     Otherwise (or bad code) -> code_err pulse and return to IDLE.
//     On reaching 8 -> HOLD, load hold_cnt = MIN_HOLD + (lfsr & HOLD_MASK).
//   HOLD: hold_seq=1. hold_cnt decrements on tick; when it is 0 on a tick -> TIMING.
//   TIMING: hold_seq=1, lights_off=1; rtime increments per tick, saturating at all-ones.
//     trig_rise -> REPORT with res_time=rtime, res_false=0.
//   REPORT: res_valid=1, hold_seq=1; res_time/res_false stable until res_valid&res_ready, then -> IDLE next cycle (all outputs drop).
//  False start: trig_rise in ARMING or HOLD -> REPORT with res_false=1, res_time=0.
//  Simultaneous events:
//   - trig_rise on the same cycle HOLD expires counts as a false start.
//   - trig_rise on the first TIMING cycle gives res_time=0, res_false=0.
//  Pattern changes while in HOLD/TIMING/REPORT are ignored; the sequencer is held.
//  Reset mid-operation aborts to IDLE immediately; a pending result is discarded.
//  Latency: lights_off asserts 1 cycle after the expiring tick; res_valid asserts 1 cycle after trig_rise.
// STRUCTURE
//  Package f1_pkg: typedef enum {IDLE, ARMING, HOLD, TIMING, REPORT} f1_rt_state_t; localparam NUM_LIGHTS=8.
//  Sub-module f1_thermo_decode: lights_in -> {lit_count, bad}, purely combinational.
//  LFSR, prescaler, counters and FSM live in the top module.
// TESTING (TICK_DIV=4, MIN_HOLD=2, HOLD_MASK=8'h03, SEED=8'hB8)
//  1 Normal: ramp 0x01..0xFF one step per 3 cycles, trigger rise 5 ticks after lights_off
//    -> res_valid=1, res_time=5, res_false=0, hold_seq=1 until handshake.
//  2 False start: trigger rise while lights_in=0x0F -> REPORT, res_false=1, res_time=0, lights_off never asserted.
//  3 Bad code: lights_in 0x03 then 0x0B -> code_err one cycle, state IDLE, lit_count=0.
//    Also 0x03 -> 0x0F (skip) -> code_err.
//  4 Backpressure: res_ready=0 for 10 cycles after res_valid -> res_time/res_false stable.
//    res_ready=1 -> res_valid=0 and hold_seq=0 on the next cycle.
//  5 Saturation: RES_W=4, no trigger for 20 ticks -> rtime holds 15; trigger -> res_time=15.
//  6 Reset mid-HOLD: assert rst for 1 cycle -> all outputs 0, IDLE.
//    The next full ramp reproduces the hold delay computed from SEED.

Source files
------------

// File: rtl/f1_reaction_timer_pkg.sv
// Shared types and helpers for the F1 start-light reaction timer.
package f1_pkg;
    localparam int NUM_LIGHTS = 8;

    typedef enum logic [2:0] {IDLE, ARMING, HOLD, TIMING, REPORT} f1_rt_state_t;

    // 8-bit Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
endpackage

// File: rtl/f1_reaction_timer_thermo_decode.sv
// Thermometer decoder: counts lit lights when the ones are contiguous from bit 0, else flags bad.
module f1_thermo_decode
    import f1_pkg::*;
(
    input  logic [NUM_LIGHTS-1:0] lights_in,
    output logic [3:0]            lit_count,
    output logic                  bad
);
    logic [NUM_LIGHTS:0] mask;

    always_comb begin
        lit_count = '0;
        bad       = 1'b1;
        mask      = '0;
        for (int n = 0; n <= NUM_LIGHTS; n++) begin
            mask = (9'd1 << n) - 9'd1;
            if (lights_in == mask[NUM_LIGHTS-1:0]) begin
                lit_count = 4'(n);
                bad       = 1'b0;
            end
        end
    end
endmodule

// File: rtl/f1_reaction_timer.sv
// F1 start-light receiver: validates the light ramp, holds for a random delay, then times the driver's reaction.
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int          TICK_DIV  = 1000,
    parameter int          MIN_HOLD  = 16,
    parameter logic [7:0]  HOLD_MASK = 8'h3F,
    parameter logic [7:0]  SEED      = 8'hB8,
    parameter int          RES_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LIGHTS-1:0] lights_in,
    input  logic                  trigger,
    output logic                  hold_seq,
    output logic                  lights_off,
    output logic [3:0]            lit_count,
    output logic                  code_err,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RES_W-1:0]      res_time,
    output logic                  res_false,
    output f1_rt_state_t          state_dbg
);
    localparam int PSC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = 16;

    f1_rt_state_t      state;
    logic [7:0]        lfsr;
    logic              trigger_q;
    logic [PSC_W-1:0]  psc;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RES_W-1:0]  rtime;
    logic [3:0]        prev_cnt;
    logic              bad;
    logic              trig_rise;
    logic              tick;

    f1_thermo_decode u_decode (
        .lights_in (lights_in),
        .lit_count (lit_count),
        .bad       (bad)
    );

    assign trig_rise = trigger & ~trigger_q;
    assign tick      = (state == HOLD || state == TIMING) && (psc == PSC_W'(TICK_DIV - 1));
    assign state_dbg = state;

    // Result handshake: res_valid rises with res_time/res_false and all three hold
    // steady until a cycle where res_valid & res_ready are both high; that cycle
    // is the transfer, and the outputs clear on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            trigger_q  <= 1'b0;
            psc        <= '0;
            hold_cnt   <= '0;
            rtime      <= '0;
            prev_cnt   <= '0;
            hold_seq   <= 1'b0;
            lights_off <= 1'b0;
            code_err   <= 1'b0;
            res_valid  <= 1'b0;
            res_time   <= '0;
            res_false  <= 1'b0;
        end else begin
            lfsr      <= lfsr_next(lfsr);
            trigger_q <= trigger;
            code_err  <= 1'b0;
            // Prescaler only runs while holding or timing; it is 0 on entry to either state.
            if (tick || !(state == HOLD || state == TIMING)) psc <= '0;
            else                                             psc <= psc + 1'b1;

            case (state)
                IDLE: begin
                    if (bad) begin
                        code_err <= 1'b1;
                    end else if (lit_count == 4'd1) begin
                        state    <= ARMING;
                        prev_cnt <= 4'd1;
                    end
                end
                ARMING: begin
                    if (trig_rise) begin
                        state     <= REPORT;
                        hold_seq  <= 1'b1;
                        res_valid <= 1'b1;
                        res_false <= 1'b1;
                        res_time  <= '0;
                    end else if (bad || (lit_count != prev_cnt && lit_count != prev_cnt + 4'd1)) begin
                        code_err <= 1'b1;
                        state    <= IDLE;
                    end else if (lit_count == 4'(NUM_LIGHTS)) begin
                        state    <= HOLD;
                        hold_seq <= 1'b1;
                        hold_cnt <= HOLD_W'(MIN_HOLD) + HOLD_W'(lfsr & HOLD_MASK);
                    end else begin
                        prev_cnt <= lit_count;
                    end
                end
                HOLD: begin
                    if (trig_rise) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                        res_false <= 1'b1;
                        res_time  <= '0;
                    end else if (tick) begin
                        if (hold_cnt == '0) begin
                            state      <= TIMING;
                            lights_off <= 1'b1;
                            rtime      <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                TIMING: begin
                    if (trig_rise) begin
                        state      <= REPORT;
                        lights_off <= 1'b0;
                        res_valid  <= 1'b1;
                        res_false  <= 1'b0;
                        res_time   <= rtime;
                    end else if (tick && rtime != '1) begin
                        rtime <= rtime + 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        hold_seq  <= 1'b0;
                        res_valid <= 1'b0;
                        res_time  <= '0;
                        res_false <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: decode vector table, hand-written corner sequences, randomized reaction trials.
module tb_f1_reaction_timer;
    import f1_pkg::*;

    localparam int         TICK_DIV  = 4;
    localparam int         MIN_HOLD  = 2;
    localparam logic [7:0] HOLD_MASK = 8'h03;
    localparam logic [7:0] SEED      = 8'hB8;
    localparam int         RES_W     = 8;
    localparam int         RES_MAX   = (1 << RES_W) - 1;

    logic             clk;
    logic             rst;
    logic [7:0]       lights_in;
    logic             trigger;
    logic             hold_seq;
    logic             lights_off;
    logic [3:0]       lit_count;
    logic             code_err;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_time;
    logic             res_false;
    f1_rt_state_t     state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] lfsr_m;
    logic [RES_W:0] exp_q[$];

    typedef struct {
        logic [7:0] lights;
        logic [3:0] exp_cnt;
        logic       exp_err;
    } vec_t;
    vec_t vecs[10];

    f1_reaction_timer #(
        .TICK_DIV  (TICK_DIV),
        .MIN_HOLD  (MIN_HOLD),
        .HOLD_MASK (HOLD_MASK),
        .SEED      (SEED),
        .RES_W     (RES_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lights_in  (lights_in),
        .trigger    (trigger),
        .hold_seq   (hold_seq),
        .lights_off (lights_off),
        .lit_count  (lit_count),
        .code_err   (code_err),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_time   (res_time),
        .res_false  (res_false),
        .state_dbg  (state_dbg)
    );

    // clock / reset-aware cycle counter and reference LFSR sequence
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        lfsr_m <= rst ? SEED : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ramp_levels(input int top);
        for (int lvl = 1; lvl <= top; lvl++) begin
            lights_in = 8'((9'd1 << lvl) - 9'd1);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        lights_in = 8'h00;
        trigger   = 1'b0;
        check("drop_res_valid", res_valid, 0);
        check("drop_hold_seq", hold_seq, 0);
        check("drop_lights_off", lights_off, 0);
        @(negedge clk);
    endtask

    // Full ramp; trigger rises 'off' cycles after the predicted lights-out cycle (negative = early).
    task automatic run_trial(input int off, input int bp);
        int f, h, span, rel, lo_first;
        logic [RES_W:0] exp_r, got;
        int tval;
        ramp_levels(7);
        lights_in = 8'hFF;
        f    = cyc;
        h    = MIN_HOLD + int'(lfsr_m & HOLD_MASK);
        span = 5 + 4 * h;
        rel  = span + off;
        if (rel < 0) rel = 0;
        lo_first = -1;
        for (int i = 0; i < rel; i++) begin
            @(negedge clk);
            if (lights_off && lo_first < 0) lo_first = cyc;
        end
        trigger = 1'b1;
        if (rel < span) begin
            exp_q.push_back({1'b1, {RES_W{1'b0}}});
        end else begin
            tval = (rel - span) / 4;
            if (tval > RES_MAX) tval = RES_MAX;
            exp_q.push_back({1'b0, RES_W'(tval)});
        end
        @(negedge clk);
        check("res_valid_latency", res_valid, 1);
        check("hold_seq_report", hold_seq, 1);
        if (rel < span) check("lights_off_never", lo_first, -1);
        else            check("lights_off_cycle", lo_first, f + span);
        got   = {res_false, res_time};
        exp_r = exp_q.pop_front();
        check("result", got, exp_r);
        res_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_stable", {res_valid, res_false, res_time}, {1'b1, got});
        end
        handshake();
    endtask

    initial begin
        rst = 1'b1; lights_in = 8'h00; trigger = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {hold_seq, lights_off, code_err, res_valid, res_false}, 0);
        check("rst_res_time", res_time, 0);
        check("rst_lit_count", lit_count, 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // decode table, applied in IDLE
        vecs[0] = '{8'h00, 4'd0, 1'b0};
        vecs[1] = '{8'h03, 4'd2, 1'b0};
        vecs[2] = '{8'h07, 4'd3, 1'b0};
        vecs[3] = '{8'h7F, 4'd7, 1'b0};
        vecs[4] = '{8'hFF, 4'd8, 1'b0};
        vecs[5] = '{8'h0B, 4'd0, 1'b1};
        vecs[6] = '{8'h80, 4'd0, 1'b1};
        vecs[7] = '{8'h02, 4'd0, 1'b1};
        vecs[8] = '{8'hFE, 4'd0, 1'b1};
        vecs[9] = '{8'h1F, 4'd5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            lights_in = vecs[i].lights;
            #1;
            check("decode_count", lit_count, vecs[i].exp_cnt);
            @(negedge clk);
            check("decode_err", code_err, vecs[i].exp_err);
            check("decode_idle", 32'(state_dbg), 32'(IDLE));
            lights_in = 8'h00;
            @(negedge clk);
            check("decode_err_clear", code_err, 0);
        end

        // bad code during ARMING: 0x03 then 0x0B
        ramp_levels(2);
        lights_in = 8'h0B;
        @(negedge clk);
        check("arm_bad_err", code_err, 1);
        check("arm_bad_state", 32'(state_dbg), 32'(IDLE));
        check("arm_bad_count", lit_count, 0);
        lights_in = 8'h00;
        @(negedge clk);
        check("arm_bad_pulse", code_err, 0);

        // skipped level: 0x03 -> 0x0F
        ramp_levels(2);
        lights_in = 8'h0F;
        @(negedge clk);
        check("arm_skip_err", code_err, 1);
        check("arm_skip_state", 32'(state_dbg), 32'(IDLE));
        lights_in = 8'h00;
        @(negedge clk);
        check("arm_skip_pulse", code_err, 0);

        // false start with 0x0F lit
        ramp_levels(4);
        trigger = 1'b1;
        @(negedge clk);
        check("fs_valid", res_valid, 1);
        check("fs_false", res_false, 1);
        check("fs_time", res_time, 0);
        check("fs_lights_off", lights_off, 0);
        check("fs_state", 32'(state_dbg), 32'(REPORT));
        handshake();

        // normal run with backpressure, then timing boundaries and saturation
        run_trial(20, 10);
        run_trial(-1, 0);
        run_trial(0, 0);
        run_trial(3, 1);
        run_trial(4, 0);
        run_trial(4 * 260, 2);

        for (int k = 0; k < 12; k++)
            run_trial(int'($urandom_range(0, 200)) - 30, int'($urandom_range(0, 4)));

        // reset in the middle of HOLD, then the next ramp restarts from SEED
        ramp_levels(7);
        lights_in = 8'hFF;
        repeat (4) @(negedge clk);
        check("mid_hold_state", 32'(state_dbg), 32'(HOLD));
        check("mid_hold_seq", hold_seq, 1);
        rst = 1'b1;
        lights_in = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outputs", {hold_seq, lights_off, code_err, res_valid, res_false}, 0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        run_trial(7, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
